// File: rtl/out_buff_drain.sv
// Read-side sequencer for the even/odd output buffer banks: issues lockstep bank reads,
// captures the 1-cycle-latency data into a 2-entry FIFO and streams packed words out.
module out_buff_drain #(
  parameter int num_pe_row         = 4,
  parameter int data_width_to_buff = 16,
  parameter int nb_data            = 8192,
  parameter int addr_width         = 13
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [addr_width-1:0]                      base_addr,
  input  logic [addr_width:0]                        num_words,
  output logic                                       busy,
  output logic                                       done,
  output logic [num_pe_row-1:0]                      rEn_even_AH,
  output logic [num_pe_row-1:0]                      rEn_odd_AH,
  output logic [num_pe_row*addr_width-1:0]           rAddr_even,
  output logic [num_pe_row*addr_width-1:0]           rAddr_odd,
  input  logic [num_pe_row*data_width_to_buff-1:0]   buff_data_out_even,
  input  logic [num_pe_row*data_width_to_buff-1:0]   buff_data_out_odd,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [2*num_pe_row*data_width_to_buff-1:0] out_data,
  output logic [1:0]                                 dbg_state
);

  localparam int D  = data_width_to_buff;
  localparam int WW = 2 * num_pe_row * D;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [addr_width-1:0] r_next_addr;
  logic [addr_width-1:0] r_last_addr;
  logic [addr_width-1:0] w_addr;
  logic [addr_width-1:0] w_addr_inc;
  logic [addr_width:0]   r_remaining;
  logic                  r_inflight;
  logic [WW-1:0]         r_fifo [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_cnt;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [2:0]            w_occ;
  logic [WW-1:0]         w_packed;

  // Handshake: a word transfers on every posedge where out_valid && out_ready; out_valid
  // never drops and out_data never changes while a word waits for out_ready.
  assign w_pop  = (r_cnt != 2'd0) && out_ready;
  assign w_push = r_inflight;
  assign w_occ  = {1'b0, r_cnt} + {2'b00, r_inflight};

  // Reserve a FIFO slot for every read in flight, so the FIFO can never overflow.
  assign w_issue = (r_state == S_RUN) && (w_occ <= 3'd1 + {2'b00, w_pop});

  assign w_addr_inc = (r_next_addr == addr_width'(nb_data - 1)) ? '0
                                                                : r_next_addr + addr_width'(1);
  assign w_addr     = w_issue ? r_next_addr : r_last_addr;

  always_comb begin
    w_packed = '0;
    for (int r = 0; r < num_pe_row; r++) begin
      w_packed[2*r*D +: D]     = buff_data_out_even[r*D +: D];
      w_packed[(2*r+1)*D +: D] = buff_data_out_odd[r*D +: D];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (num_words == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_issue && (r_remaining == (addr_width+1)'(1))) w_next = S_FLUSH;
      S_FLUSH: if (!r_inflight && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop)))
                 w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_next_addr <= '0;
      r_last_addr <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_cnt       <= 2'd0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if ((r_state == S_IDLE) && start) begin
        r_next_addr <= base_addr;
        r_remaining <= num_words;
      end
      if (w_issue) begin
        r_last_addr <= r_next_addr;
        r_next_addr <= w_addr_inc;
        r_remaining <= r_remaining - (addr_width+1)'(1);
      end
      if (w_push) begin
        r_fifo[r_wptr] <= w_packed;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign rEn_even_AH = {num_pe_row{w_issue}};
  assign rEn_odd_AH  = {num_pe_row{w_issue}};
  assign rAddr_even  = {num_pe_row{w_addr}};
  assign rAddr_odd   = {num_pe_row{w_addr}};
  assign out_valid   = (r_cnt != 2'd0);
  assign out_data    = out_valid ? r_fifo[r_rptr] : '0;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_out_buff_drain.sv
// Self-checking bench for out_buff_drain: bank memory model, expected address/word
// queues built from the drain rules, and a negedge monitor.
module tb_out_buff_drain;

  localparam int R  = 4;
  localparam int D  = 16;
  localparam int AW = 13;
  localparam int NB = 8192;
  localparam int WW = 2 * R * D;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [AW:0]       num_words = '0;
  logic              busy, done, out_valid;
  logic              out_ready = 1'b0;
  logic [R-1:0]      rEn_even_AH, rEn_odd_AH;
  logic [R*AW-1:0]   rAddr_even, rAddr_odd;
  logic [R*D-1:0]    buff_data_out_even = '0;
  logic [R*D-1:0]    buff_data_out_odd = '0;
  logic [WW-1:0]     out_data;
  logic [1:0]        dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  logic [D-1:0]  mem_e [R][NB];
  logic [D-1:0]  mem_o [R][NB];
  logic [AW-1:0] addr_q [$];
  logic [WW-1:0] exp_q [$];

  logic [AW-1:0] last_addr = '0;
  int            n_iss = 0;
  int            n_pop = 0;
  int            done_cnt = 0;
  logic          pend_done = 1'b0;
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_data = '0;
  logic          exp_zero = 1'b0;

  out_buff_drain dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .rEn_even_AH(rEn_even_AH), .rEn_odd_AH(rEn_odd_AH),
    .rAddr_even(rAddr_even), .rAddr_odd(rAddr_odd),
    .buff_data_out_even(buff_data_out_even), .buff_data_out_odd(buff_data_out_odd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Buffer banks: read data appears one cycle after rEn.
  always @(posedge clk) begin
    for (int r = 0; r < R; r++) begin
      if (rEn_even_AH[r] === 1'b1) buff_data_out_even[r*D +: D] <= mem_e[r][rAddr_even[r*AW +: AW]];
      if (rEn_odd_AH[r] === 1'b1)  buff_data_out_odd[r*D +: D]  <= mem_o[r][rAddr_odd[r*AW +: AW]];
    end
  end

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack(input logic [AW-1:0] a);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < R; r++) begin
      w[2*r*D +: D]     = mem_e[r][a];
      w[(2*r+1)*D +: D] = mem_o[r][a];
    end
    return w;
  endfunction

  // Expected reads and words of a drain: addresses base..base+n-1 modulo buffer depth.
  task automatic push_exp(input logic [AW-1:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      logic [AW-1:0] a;
      a = AW'((int'(b) + k) % NB);
      addr_q.push_back(a);
      exp_q.push_back(pack(a));
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic issue, pop, last_pop;
    if (rst) begin
      addr_q.delete();
      exp_q.delete();
      n_iss = 0;
      n_pop = 0;
      pend_done = 1'b0;
      prev_stall = 1'b0;
      last_addr = '0;
    end else begin
      issue = |{rEn_even_AH, rEn_odd_AH};
      pop = out_valid && out_ready;
      last_pop = 1'b0;
      check("ren_even_all", rEn_even_AH, {R{issue}});
      check("ren_odd_all", rEn_odd_AH, {R{issue}});
      if (issue) begin
        check("ren_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) begin
          check("raddr", {rAddr_even, rAddr_odd}, {2*R{addr_q[0]}});
          last_addr = addr_q.pop_front();
        end
        check("no_overflow", (n_iss - n_pop - int'(pop)) <= 1, 1);
        n_iss++;
      end else begin
        check("raddr_hold", {rAddr_even, rAddr_odd}, {2*R{last_addr}});
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
      if (pop) begin
        check("pop_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("data", out_data, exp_q.pop_front());
          last_pop = (exp_q.size() == 0);
        end
        n_pop++;
      end
      check("done", done, pend_done);
      if (done) done_cnt++;
      pend_done = last_pop || exp_zero;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  // driver: mode 0 ready always, 1 pattern 1,0,0, 2 random
  task automatic run_drain(input logic [AW-1:0] b, input int n, input int mode,
                           input bit chk_lat, input bit busy_pulse);
    int  cyc;
    int  d0;
    bit  got;
    push_exp(b, n);
    d0 = done_cnt;
    if (mode == 0) out_ready = 1'b1;
    base_addr = b;
    num_words = (AW+1)'(n);
    start = 1'b1;
    exp_zero = (n == 0);
    @(posedge clk); #1;
    start = 1'b0;
    exp_zero = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < n * 6 + 40) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (busy_pulse && cyc == 3) begin
        start = 1'b1;
        base_addr = AW'($urandom_range(0, NB - 1));
        num_words = (AW+1)'(5);
      end
      @(negedge clk);
      if (cyc == 0) check("busy_after_start", busy, 1);
      if (n == 0 && cyc == 0) check("zero_done", done, 1);
      if (chk_lat) begin
        if (cyc <= 3) check("ren_burst", rEn_even_AH, {R{1'b1}});
        if (cyc == 4) check("ren_stop", rEn_even_AH, '0);
        if (cyc == 1) check("valid_early", out_valid, 0);
        if (cyc == 2) check("first_valid", out_valid, 1);
        if (cyc == 6) check("done_after_last_pop", done, 1);
      end
      @(posedge clk); #1;
      start = 1'b0;
      got = (done_cnt != d0);
      cyc++;
    end
    check("drain_complete", got, 1);
    check("words_left", exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] b;
    for (int r = 0; r < R; r++) begin
      for (int a = 0; a < NB; a++) begin
        mem_e[r][a] = D'($urandom);
        mem_o[r][a] = D'($urandom);
      end
      for (int a = 0; a < 4; a++) begin
        mem_e[r][a] = D'(100 + a);
        mem_o[r][a] = D'(200 + a);
      end
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {busy, done, rEn_even_AH, rEn_odd_AH, out_valid}, '0);
    check("rst_addr", {rAddr_even, rAddr_odd}, '0);
    check("rst_data", out_data, '0);
    check("rst_state", dbg_state, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    check("word0_model", pack(0), {96'd0, 16'd200, 16'd100} | {{3{16'd200, 16'd100}}, 32'd0});
    run_drain(0, 4, 0, 1'b1, 1'b0);
    run_drain(0, 4, 1, 1'b0, 1'b0);
    run_drain(AW'(8190), 4, 0, 1'b0, 1'b0);
    run_drain(AW'(8190), 4, 2, 1'b0, 1'b0);
    run_drain(AW'(37), 0, 0, 1'b0, 1'b0);
    run_drain(AW'($urandom_range(0, NB - 1)), 30, 2, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      run_drain(AW'($urandom_range(0, NB - 1)), $urandom_range(1, 40), $urandom_range(0, 2),
                1'b0, 1'b0);
    run_drain(AW'(NB - 1 - $urandom_range(0, 5)), 12, 2, 1'b0, 1'b0);

    // Reset in the middle of a drain.
    b = AW'($urandom_range(0, NB - 1));
    push_exp(b, 20);
    base_addr = b;
    num_words = (AW+1)'(20);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_state", dbg_state, 2'd0);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    check("midrst_valid2", out_valid, 0);
    @(posedge clk); #1;
    run_drain(0, 2, 0, 1'b0, 1'b0);
    check("midrst_words", n_pop, 2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
